serial_adder: RTL and testbench

Bit-serial ripple adder that reuses a single full-adder cell across WIDTH clock cycles. It adds two WIDTH-bit operands plus carry-in, LSB first, and returns a registered WIDTH-bit sum and carry-out through a start/busy/done handshake. It is the sequential counterpart of the lab full-adder cell and is intended as the area-minimal adder for the lab datapath.

---
 rtl/serial_adder_if.sv | 26 ++
 rtl/serial_adder.sv | 113 +++++++++++
 tb/tb_serial_adder.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_if.sv
// serial_adder_if: start/busy/done handshake bundle for the bit-serial adder.
//   master : requester, drives start/a/b/cin and observes busy/done/sum/cout
//   slave  : the adder itself
// WIDTH must match the WIDTH of the serial_adder instance it is bound to.
interface serial_adder_if #(
  parameter int WIDTH = 8
) ();
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/serial_adder.sv
// serial_adder: bit-serial ripple adder built around one full-adder cell.
// The cell is reused once per bit, LSB first, so one add takes WIDTH cycles
// in RUN, plus one DONE cycle before the block is idle again.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : serial_adder_if.slave
//           start/a/b/cin sampled only on the accepting edge (IDLE),
//           busy high in RUN, done one-cycle pulse,
//           sum/cout registered and held until the next completion.

// One full-adder cell; the whole datapath is this cell plus shift registers.
module serial_adder_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_adder_if.slave  bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic             c;
  logic [CW-1:0]    cnt;

  logic             s;
  logic             c_nx;
  logic [WIDTH-1:0] sum_nx;

  serial_adder_fa u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (c),
    .s  (s),
    .co (c_nx)
  );

  // New bit enters at the MSB; after WIDTH shifts bit 0 lands at index 0.
  if (WIDTH > 1) begin : g_sh
    assign sum_nx = {s, sum_sh[WIDTH-1:1]};
  end else begin : g_sh1
    assign sum_nx = s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_sh     <= '0;
      b_sh     <= '0;
      sum_sh   <= '0;
      c        <= 1'b0;
      cnt      <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.sum  <= '0;
      bus.cout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_sh     <= bus.a;
            b_sh     <= bus.b;
            c        <= bus.cin;
            sum_sh   <= '0;
            cnt      <= '0;
            bus.busy <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          c      <= c_nx;
          sum_sh <= sum_nx;
          cnt    <= cnt + 1'b1;
          // Last bit: publish from the next-values so this bit is included.
          if (cnt == CW'(WIDTH - 1)) begin
            bus.sum  <= sum_nx;
            bus.cout <= c_nx;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          // start is ignored here; earliest re-accept is the edge after this.
          bus.done <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: a WIDTH=8 and a WIDTH=1 instance share
// the clock and reset. Drivers push expected results; monitors pop on done.
module tb_serial_adder;
  logic clk;
  logic rst_n;
  int   cyc;
  int   n_cmp;
  int   n_bad;

  typedef struct {
    logic [7:0] sum;
    logic       cout;
    int         done_cyc;
  } exp_t;

  exp_t q8[$];
  exp_t q1[$];

  serial_adder_if #(.WIDTH(8)) b8 ();
  serial_adder_if #(.WIDTH(1)) b1 ();

  serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));
  serial_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitors: every done must match the head of its queue, on the right cycle.
  always @(negedge clk) begin
    exp_t e;
    if (b8.done === 1'b1) begin
      if (q8.size() == 0) chk("w8_unexpected_done", 32'd1, 32'd0);
      else begin
        e = q8.pop_front();
        chk("w8_sum", {24'd0, b8.sum}, {24'd0, e.sum});
        chk("w8_cout", {31'd0, b8.cout}, {31'd0, e.cout});
        chk("w8_done_cycle", cyc, e.done_cyc);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (b1.done === 1'b1) begin
      if (q1.size() == 0) chk("w1_unexpected_done", 32'd1, 32'd0);
      else begin
        e = q1.pop_front();
        chk("w1_sum", {31'd0, b1.sum}, {31'd0, e.sum[0]});
        chk("w1_cout", {31'd0, b1.cout}, {31'd0, e.cout});
        chk("w1_done_cycle", cyc, e.done_cyc);
      end
    end
  end

  // Directed WIDTH=8 op with hand-computed result; checks busy E0..E7 and low at E8.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                     input logic [7:0] es, input logic ec);
    exp_t e;
    @(negedge clk);
    b8.start = 1'b1; b8.a = a; b8.b = b; b8.cin = c;
    @(posedge clk); #1;
    e.sum = es; e.cout = ec; e.done_cyc = cyc + 8;
    q8.push_back(e);
    @(negedge clk);
    b8.start = 1'b0;
    chk("w8_busy_run", {31'd0, b8.busy}, 32'd1);
    for (int k = 1; k < 8; k++) begin
      @(negedge clk);
      chk("w8_busy_run", {31'd0, b8.busy}, 32'd1);
    end
    @(negedge clk);
    chk("w8_busy_done", {31'd0, b8.busy}, 32'd0);
    @(posedge clk);
  endtask

  task automatic op1(input logic a, input logic b, input logic c,
                     input logic es, input logic ec);
    exp_t e;
    @(negedge clk);
    b1.start = 1'b1; b1.a = a; b1.b = b; b1.cin = c;
    @(posedge clk); #1;
    e.sum = {7'd0, es}; e.cout = ec; e.done_cyc = cyc + 1;
    q1.push_back(e);
    @(negedge clk);
    b1.start = 1'b0;
    chk("w1_busy_run", {31'd0, b1.busy}, 32'd1);
    @(negedge clk);
    chk("w1_busy_done", {31'd0, b1.busy}, 32'd0);
    @(posedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ra, rb;
    logic       rc;
    logic [8:0] ref_sum;
    exp_t       e;
    n_cmp = 0; n_bad = 0;
    rst_n = 1'b0;
    b8.start = 1'b0; b8.a = '0; b8.b = '0; b8.cin = 1'b0;
    b1.start = 1'b0; b1.a = '0; b1.b = '0; b1.cin = 1'b0;
    #12;
    chk("rst_busy", {31'd0, b8.busy}, 32'd0);
    chk("rst_done", {31'd0, b8.done}, 32'd0);
    chk("rst_sum", {24'd0, b8.sum}, 32'd0);
    chk("rst_cout", {31'd0, b8.cout}, 32'd0);
    chk("rst_w1_sum", {31'd0, b1.sum}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // WIDTH=1 full-adder truth table
    op1(0, 0, 0, 0, 0);
    op1(0, 0, 1, 1, 0);
    op1(0, 1, 0, 1, 0);
    op1(0, 1, 1, 0, 1);
    op1(1, 0, 0, 1, 0);
    op1(1, 0, 1, 0, 1);
    op1(1, 1, 0, 0, 1);
    op1(1, 1, 1, 1, 1);

    // WIDTH=8 directed
    op8(8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    op8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    op8(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1);
    op8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0);

    // start pulses at E3 and E8 must be ignored; old sum held until E8
    @(negedge clk);
    b8.start = 1'b1; b8.a = 8'h12; b8.b = 8'h34; b8.cin = 1'b0;
    @(posedge clk); #1;
    e.sum = 8'h46; e.cout = 1'b0; e.done_cyc = cyc + 8;
    q8.push_back(e);
    @(negedge clk);
    for (int k = 1; k <= 9; k++) begin
      if (k == 3 || k == 8) begin
        b8.start = 1'b1; b8.a = 8'hFF; b8.b = 8'hFF;
      end else b8.start = 1'b0;
      if (k <= 8) begin
        chk("w8_sum_held", {24'd0, b8.sum}, 32'h80);
        chk("w8_busy_held", {31'd0, b8.busy}, 32'd1);
      end
      @(posedge clk); @(negedge clk);
    end
    b8.start = 1'b0;
    @(posedge clk);

    // reset mid-RUN at E4: immediate clear, no done afterwards
    @(negedge clk);
    b8.start = 1'b1; b8.a = 8'hF0; b8.b = 8'h0F; b8.cin = 1'b0;
    @(posedge clk);
    @(negedge clk);
    b8.start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, b8.busy}, 32'd0);
    chk("abort_done", {31'd0, b8.done}, 32'd0);
    chk("abort_sum", {24'd0, b8.sum}, 32'd0);
    chk("abort_cout", {31'd0, b8.cout}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("abort_sum_after", {24'd0, b8.sum}, 32'd0);
    op8(8'h01, 8'h02, 1'b0, 8'h03, 1'b0);

    // start held high: one accept every 10 cycles, random operands
    @(negedge clk);
    b8.start = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      b8.a = ra; b8.b = rb; b8.cin = rc;
      @(posedge clk); #1;
      ref_sum = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
      e.sum = ref_sum[7:0]; e.cout = ref_sum[8]; e.done_cyc = cyc + 8;
      q8.push_back(e);
      repeat (9) @(posedge clk);
      @(negedge clk);
      if (n == 999) b8.start = 1'b0;
    end

    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("w8_queue_drained", q8.size(), 32'd0);
    chk("w1_queue_drained", q1.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
